// File: rtl/decim_word_serializer_if.sv
// Filter-side strobe/data inputs and serial-link/status outputs of decim_word_serializer.
interface decim_word_serializer_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
);
  logic [WIDTH-1:0]       din;
  logic                   din_valid;
  logic                   clr_ovf;
  logic                   ser_sclk;
  logic                   ser_data;
  logic                   ser_fs;
  logic                   busy;
  logic                   overflow;
  logic [$clog2(DEPTH):0] fifo_level;

  modport master (
    output din, din_valid, clr_ovf,
    input  ser_sclk, ser_data, ser_fs, busy, overflow, fifo_level
  );

  modport slave (
    input  din, din_valid, clr_ovf,
    output ser_sclk, ser_data, ser_fs, busy, overflow, fifo_level
  );
endinterface

// File: rtl/decim_word_serializer.sv
// Buffers decimated words in a small FIFO and ships them MSB first on a frame-synced 3-wire link.
// Optional macro DECIM_SER_PARITY_EN appends an even-parity bit period after the payload.
module decim_word_serializer #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 4,
  parameter int CLK_DIV = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  decim_word_serializer_if.slave  sif
);

  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW   = PW + 1;
  localparam int DIVW = $clog2(2 * CLK_DIV);
  localparam int BW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(2 * CLK_DIV - 1);
  localparam logic [DIVW-1:0] DIV_HALF = DIVW'(CLK_DIV);
  localparam logic [BW-1:0]   BIT_LAST = BW'(WIDTH - 1);
  localparam logic [LW-1:0]   LVL_FULL = LW'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FSYNC,
    ST_SHIFT,
    ST_PARITY,
    ST_GAP
  } state_e;

  logic [WIDTH-1:0] mem [DEPTH];

  state_e           state_q, state_d;
  logic [DIVW-1:0]  div_q, div_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q, level_d;
  logic             ovf_q;
`ifdef DECIM_SER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic pop, push, drop, full, period_end;

  // A pop only happens from IDLE, so a write into a full FIFO is safe exactly when that pop frees a slot.
  always_comb begin
    full       = (level_q == LVL_FULL);
    pop        = (state_q == ST_IDLE) && (level_q != '0);
    push       = sif.din_valid && (!full || pop);
    drop       = sif.din_valid && full && !pop;
    period_end = (div_q == DIV_LAST);

    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
`ifdef DECIM_SER_PARITY_EN
    parity_d = parity_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        div_d = '0;
        bit_d = '0;
        if (pop) begin
          shift_d = mem[rd_ptr_q];
`ifdef DECIM_SER_PARITY_EN
          parity_d = ^mem[rd_ptr_q];
`endif
          state_d = ST_FSYNC;
        end
      end
      ST_FSYNC: begin
        div_d = div_q + DIVW'(1);
        if (period_end) begin
          div_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        div_d = div_q + DIVW'(1);
        if (period_end) begin
          div_d   = '0;
          shift_d = {shift_q[WIDTH-2:0], 1'b0};
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
`ifdef DECIM_SER_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_GAP;
`endif
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
`ifdef DECIM_SER_PARITY_EN
      ST_PARITY: begin
        div_d = div_q + DIVW'(1);
        if (period_end) begin
          div_d   = '0;
          state_d = ST_GAP;
        end
      end
`endif
      ST_GAP: begin
        div_d = div_q + DIVW'(1);
        if (period_end) begin
          div_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        div_d   = '0;
        bit_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
`ifdef DECIM_SER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      level_q <= level_d;
`ifdef DECIM_SER_PARITY_EN
      parity_q <= parity_d;
`endif
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      // A drop on the same edge as a clear keeps the flag set.
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (sif.clr_ovf) begin
        ovf_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem[wr_ptr_q] <= sif.din;
    end
  end

  assign sif.busy       = (state_q != ST_IDLE);
  assign sif.ser_fs     = (state_q == ST_FSYNC);
  assign sif.ser_sclk   = ((state_q == ST_FSYNC) || (state_q == ST_SHIFT) || (state_q == ST_PARITY))
                          && (div_q >= DIV_HALF);
`ifdef DECIM_SER_PARITY_EN
  assign sif.ser_data   = (state_q == ST_SHIFT)  ? shift_q[WIDTH-1] :
                          (state_q == ST_PARITY) ? parity_q : 1'b0;
`else
  assign sif.ser_data   = (state_q == ST_SHIFT) && shift_q[WIDTH-1];
`endif
  assign sif.overflow   = ovf_q;
  assign sif.fifo_level = level_q;

endmodule

// File: tb/tb_decim_word_serializer.sv
// Randomized and directed bench for decim_word_serializer against a queue/timer reference model.
`timescale 1ns/1ps
module tb_decim_word_serializer;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
`ifdef DECIM_SER_PARITY_EN
  localparam int NBITS = WIDTH + 3;
`else
  localparam int NBITS = WIDTH + 2;
`endif
  localparam int FRAME1 = NBITS * 2;
  localparam int FRAME3 = NBITS * 6;

  logic clk = 1'b0;
  logic rst;
  logic rst3;
  always #5 clk = ~clk;

  decim_word_serializer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus1 ();
  decim_word_serializer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus3 ();

  decim_word_serializer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CLK_DIV(1)) u_dut (
    .clk   (clk),
    .reset (rst),
    .sif   (bus1)
  );

  decim_word_serializer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CLK_DIV(3)) u_dut3 (
    .clk   (clk),
    .reset (rst3),
    .sif   (bus3)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Reference model: FIFO contents, words handed to the link, and a link-busy countdown.
  logic [WIDTH-1:0] m_fifo[$];
  logic [WIDTH-1:0] m_tx[$];
  int  m_timer = 0;
  bit  m_ovf = 1'b0;
  bit  m_rst_seen = 1'b0;
  bit  m_pop;
  bit  m_drop;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_fifo.delete();
        m_tx.delete();
        m_timer    = 0;
        m_ovf      = 1'b0;
        m_rst_seen = 1'b1;
      end else begin
        m_pop = (m_timer == 0) && (m_fifo.size() > 0);
        if (m_timer > 0) m_timer--;
        if (m_pop) begin
          m_tx.push_back(m_fifo.pop_front());
          m_timer = FRAME1;
        end
        m_drop = 1'b0;
        if (bus1.din_valid) begin
          if (m_fifo.size() < DEPTH) m_fifo.push_back(bus1.din);
          else m_drop = 1'b1;
        end
        if (m_drop) m_ovf = 1'b1;
        else if (bus1.clr_ovf) m_ovf = 1'b0;
      end
    end
  end

  // Per-cycle status comparison and serial frame decoder for the CLK_DIV=1 instance.
  bit chk_en = 1'b0;
  bit prev_sclk = 1'b0;
  bit in_frame = 1'b0;
  int nb = 0;
  logic [WIDTH-1:0] rx_word = '0;

  task automatic finish_frame();
    check_val("tx_avail", 32'(m_tx.size()), 32'd1);
    if (m_tx.size() > 0) check_val("frame_word", 32'(rx_word), 32'(m_tx.pop_front()));
    in_frame = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (m_rst_seen) begin
        m_rst_seen = 1'b0;
        in_frame   = 1'b0;
        prev_sclk  = 1'b0;
      end
      if (chk_en) begin
        check_val("busy", 32'(bus1.busy), 32'(m_timer != 0));
        check_val("level", 32'(bus1.fifo_level), 32'(m_fifo.size()));
        check_val("ovf", 32'(bus1.overflow), 32'(m_ovf));
        if (m_timer == 0)
          check_val("idle_lines", 32'({bus1.ser_sclk, bus1.ser_data, bus1.ser_fs}), 32'd0);
        else if (m_timer <= 2)
          check_val("gap_sclk", 32'(bus1.ser_sclk), 32'd0);
      end
      if (bus1.ser_sclk && !prev_sclk) begin
        if (bus1.ser_fs) begin
          in_frame = 1'b1;
          nb       = 0;
          rx_word  = '0;
        end else if (in_frame) begin
          if (nb < WIDTH) begin
            rx_word = {rx_word[WIDTH-2:0], bus1.ser_data};
            nb++;
`ifndef DECIM_SER_PARITY_EN
            if (nb == WIDTH) finish_frame();
`endif
          end else begin
            check_val("parity", 32'(bus1.ser_data), 32'(^rx_word));
            finish_frame();
          end
        end
      end
      prev_sclk = bus1.ser_sclk;
    end
  end

  task automatic send1(input logic [WIDTH-1:0] w);
    bus1.din       = w;
    bus1.din_valid = 1'b1;
    @(negedge clk);
    bus1.din_valid = 1'b0;
  endtask

  task automatic wait_idle1(input int bound);
    int n;
    n = 0;
    while ((bus1.busy || bus1.fifo_level != 0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (n >= bound) check_val("drain_timeout", 32'({bus1.busy, bus1.fifo_level}), 32'd0);
    repeat (3) @(negedge clk);
    check_val("tx_pending", 32'(m_tx.size()), 32'd0);
  endtask

  int busy3, run3, nbit3, n3;
  bit seen_fs3, prev3, par3;
  logic [WIDTH-1:0] w3;

  initial begin
    rst = 1'b1;
    rst3 = 1'b1;
    bus1.din = '0; bus1.din_valid = 1'b0; bus1.clr_ovf = 1'b0;
    bus3.din = '0; bus3.din_valid = 1'b0; bus3.clr_ovf = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rst3 = 1'b0;
    check_val("rst_outputs", 32'({bus1.ser_sclk, bus1.ser_data, bus1.ser_fs, bus1.busy, bus1.overflow}), 32'd0);
    check_val("rst_level", 32'(bus1.fifo_level), 32'd0);

    // Single word: level, frame-sync window, then full frame via decoder
    send1(16'hA5C3);
    check_val("a5_level", 32'(bus1.fifo_level), 32'd1);
    @(negedge clk);
    check_val("a5_fs_first", 32'(bus1.ser_fs), 32'd1);
    @(negedge clk);
    check_val("a5_fs_second", 32'(bus1.ser_fs), 32'd1);
    @(negedge clk);
    check_val("a5_fs_after", 32'(bus1.ser_fs), 32'd0);
    wait_idle1(200);

    // Five words back to back, then a sixth into a full FIFO
    for (int i = 1; i <= 5; i++) send1(WIDTH'(i));
    check_val("fill_level", 32'(bus1.fifo_level), 32'd4);
    check_val("fill_no_ovf", 32'(bus1.overflow), 32'd0);
    send1(16'h0006);
    check_val("drop_sets_ovf", 32'(bus1.overflow), 32'd1);

    // Clear on the same edge as another drop: set wins
    bus1.clr_ovf = 1'b1;
    send1(16'h0007);
    bus1.clr_ovf = 1'b0;
    check_val("clr_vs_drop", 32'(bus1.overflow), 32'd1);
    bus1.clr_ovf = 1'b1;
    @(negedge clk);
    bus1.clr_ovf = 1'b0;
    check_val("clr_alone", 32'(bus1.overflow), 32'd0);
    wait_idle1(400);

    // Reset during SHIFT bit 7 of FFFF, then a clean frame
    send1(16'hFFFF);
    repeat (17) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("midrst_outputs", 32'({bus1.ser_sclk, bus1.ser_data, bus1.ser_fs, bus1.busy, bus1.overflow}), 32'd0);
    check_val("midrst_level", 32'(bus1.fifo_level), 32'd0);
    send1(16'h1234);
    wait_idle1(200);
    send1(16'h0007);
    wait_idle1(200);
    send1(16'h0003);
    wait_idle1(200);

    // Random traffic with occasional clears and resets
    for (int i = 0; i < 1500; i++) begin
      bus1.din       = WIDTH'($urandom);
      bus1.din_valid = ($urandom_range(0, 9) == 0);
      bus1.clr_ovf   = ($urandom_range(0, 19) == 0);
      rst            = ($urandom_range(0, 399) == 0);
      @(negedge clk);
    end
    bus1.din_valid = 1'b0;
    bus1.clr_ovf   = 1'b0;
    rst            = 1'b0;
    wait_idle1(1000);

    // CLK_DIV=3 instance: phase lengths, bit content and frame length
    bus3.din = 16'h8001;
    bus3.din_valid = 1'b1;
    @(negedge clk);
    bus3.din_valid = 1'b0;
    busy3 = 0; run3 = 0; nbit3 = 0; n3 = 0;
    seen_fs3 = 1'b0; prev3 = 1'b0; par3 = 1'b0; w3 = '0;
    while (n3 < 400 && !(busy3 > 0 && !bus3.busy)) begin
      @(negedge clk);
      n3++;
      if (bus3.busy) begin
        busy3++;
        if (bus3.ser_sclk != prev3) begin
          if (prev3) check_val("div3_high", 32'(run3), 32'd3);
          else check_val("div3_low", 32'(run3), 32'd3);
          run3 = 0;
        end
        run3++;
        if (bus3.ser_sclk && !prev3) begin
          if (bus3.ser_fs) seen_fs3 = 1'b1;
          else if (nbit3 < WIDTH) begin
            w3 = {w3[WIDTH-2:0], bus3.ser_data};
            nbit3++;
          end else par3 = bus3.ser_data;
        end
      end
      prev3 = bus3.ser_sclk;
    end
    if (n3 >= 400) check_val("div3_timeout", 32'(bus3.busy), 32'd0);
    check_val("div3_fs", 32'(seen_fs3), 32'd1);
    check_val("div3_word", 32'(w3), 32'h8001);
    check_val("div3_frame_len", 32'(busy3), 32'(FRAME3));
`ifdef DECIM_SER_PARITY_EN
    check_val("div3_parity", 32'(par3), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
